// File: rtl/streamer_pkg.sv
// streamer_pkg: shared opcode constants, FSM states and instruction-class decode
package streamer_pkg;
  localparam logic [1:0] OP_GENERIC = 2'b00;
  localparam logic [1:0] OP_LOADI = 2'b01;
  localparam logic [1:0] OP_OPERATE = 2'b10;
  localparam logic [1:0] OP_BURST = 2'b11;
  localparam int BURST_SEL_BIT = 2;
  localparam logic [1:0] GENERIC_RESET_SEL = 2'b11;
  localparam logic [15:0] NOP_INSTRUCTION = 16'h0000;
  typedef enum logic [1:0] {ISSUE, PAYLOAD, PAD} state_t;
  typedef enum logic [2:0] {
    CLS_GENERIC, CLS_RESET, CLS_LOADI, CLS_OPERATE, CLS_BURST_READ, CLS_BURST_WRITE
  } iclass_t;
  function automatic iclass_t decode(input logic [15:0] w);
    return (w[1:0] == OP_GENERIC) ? ((w[3:2] == GENERIC_RESET_SEL) ? CLS_RESET : CLS_GENERIC) :
           (w[1:0] == OP_LOADI)   ? CLS_LOADI :
           (w[1:0] == OP_OPERATE) ? CLS_OPERATE :
           w[BURST_SEL_BIT]       ? CLS_BURST_WRITE : CLS_BURST_READ;
  endfunction
endpackage

// File: rtl/instruction_fifo.sv
// instruction_fifo: word FIFO with head peek, occupancy level and power-of-two wrapping pointers
module instruction_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic do_push, do_pop;
  assign do_push = push_i && (level_q != LW'(DEPTH));
  assign do_pop = pop_i && (level_q != '0);
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wptr_q] <= wdata_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(do_push);
      rptr_q <= rptr_q + AW'(do_pop);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  assign head_o = mem_q[rptr_q];
  assign level_o = level_q;
endmodule

// File: rtl/instruction_streamer.sv
// instruction_streamer: assembles host bytes into instruction words and issues them to the cpu,
// holding burst writes until complete and padding burst reads / operates with NOPs
module instruction_streamer
  import streamer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_WRITE_PAYLOAD = 5,
  parameter int BURST_READ_PAD = 9,
  parameter int OPERATE_PAD = 5
) (
  input  logic                          clock_in,
  input  logic                          reset_n_in,
  input  logic [7:0]                    host_byte_in,
  input  logic                          host_valid_in,
  output logic                          host_ready_out,
  output logic [15:0]                   current_instruction_out,
  output logic                          instruction_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          busy_out
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = 8;
  logic phase_q, phase_d;
  logic [7:0] hi_q, hi_d;
  logic accept, push, pop, empty;
  logic [15:0] head;
  logic [LW-1:0] level;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] instr_q, instr_d;
  logic valid_q, valid_d;
  iclass_t cls;
  assign host_ready_out = reset_n_in && (level < LW'(FIFO_DEPTH));
  assign accept = host_valid_in && host_ready_out;
  assign push = accept && phase_q;
  assign phase_d = accept ? ~phase_q : phase_q;
  assign hi_d = (accept && !phase_q) ? host_byte_in : hi_q;
  assign empty = (level == '0);
  assign cls = decode(head);
  instruction_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk_i   (clock_in),
    .rst_ni  (reset_n_in),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({hi_q, host_byte_in}),
    .head_o  (head),
    .level_o (level)
  );
  // A burst-write header only leaves once its whole payload is queued, so PAYLOAD never starves
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pop = 1'b0;
    instr_d = NOP_INSTRUCTION;
    valid_d = 1'b0;
    unique case (state_q)
      ISSUE: if (!empty) begin
        if (cls != CLS_BURST_WRITE || level >= LW'(1 + BURST_WRITE_PAYLOAD)) begin
          pop = 1'b1;
          instr_d = head;
          valid_d = 1'b1;
        end
        if (cls == CLS_OPERATE) begin
          state_d = PAD;
          cnt_d = CW'(OPERATE_PAD);
        end else if (cls == CLS_BURST_READ) begin
          state_d = PAD;
          cnt_d = CW'(BURST_READ_PAD);
        end else if (cls == CLS_BURST_WRITE && pop) begin
          state_d = PAYLOAD;
          cnt_d = CW'(BURST_WRITE_PAYLOAD);
        end
      end
      PAYLOAD: begin
        pop = 1'b1;
        instr_d = head;
        valid_d = 1'b1;
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? ISSUE : PAYLOAD;
      end
      PAD: if (!empty && cls == CLS_RESET) begin
        pop = 1'b1;
        instr_d = head;
        valid_d = 1'b1;
        cnt_d = '0;
        state_d = ISSUE;
      end else begin
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? ISSUE : PAD;
      end
      default: state_d = ISSUE;
    endcase
  end
  always_ff @(posedge clock_in or negedge reset_n_in)
    if (!reset_n_in) begin
      state_q <= ISSUE;
      cnt_q <= '0;
      instr_q <= NOP_INSTRUCTION;
      valid_q <= 1'b0;
      phase_q <= 1'b0;
      hi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
      hi_q <= hi_d;
    end
  assign current_instruction_out = instr_q;
  assign instruction_valid_out = valid_q;
  assign fifo_level_out = level;
  assign busy_out = (state_q != ISSUE) || !empty;
endmodule
